// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming KxK multi-channel sliding-window generator.
// Takes one raster-order pixel per accepted cycle, keeps K-1 previous rows in
// line buffers, and emits stride-1, unpadded windows packed for the MAC stage.
// Optional build macro: CONV_WINDOW_GEN_BACKPRESSURE_EN adds win_ready and
// holds each window until the consumer takes it.
module conv_window_gen #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IN_CHANNEL  = 3,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   pixel_valid,
    input  logic [IN_CHANNEL*DATA_WIDTH-1:0]                       pixel_in,
    output logic                                                   pixel_ready,
`ifdef CONV_WINDOW_GEN_BACKPRESSURE_EN
    input  logic                                                   win_ready,
`endif
    output logic                                                   window_valid,
    output logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_data,
    output logic                                                   frame_done
);

    localparam int K  = KERNEL_SIZE;
    localparam int PW = IN_CHANNEL * DATA_WIDTH;
    localparam int WW = IN_CHANNEL * K * K * DATA_WIDTH;
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [PW-1:0]         lb       [K-1][IMG_WIDTH];
    logic [PW-1:0]         col_vec  [K];
    logic [DATA_WIDTH-1:0] win      [IN_CHANNEL][K][K];
    logic [DATA_WIDTH-1:0] win_next [IN_CHANNEL][K][K];
    logic [WW-1:0]         win_flat;
    logic                  accept;
    logic                  emit;
    logic                  col_last;
    logic                  row_last;

`ifdef CONV_WINDOW_GEN_BACKPRESSURE_EN
    // Stall the input only while an untaken window is pending.
    assign pixel_ready = !window_valid || win_ready;
`else
    assign pixel_ready = 1'b1;
`endif

    assign accept   = pixel_valid && pixel_ready;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    // Only pixels whose window lies fully inside the frame produce output.
    assign emit     = accept && (row >= ROW_FIRST) && (col >= COL_FIRST);

    // Column vector for the current column, oldest row first; line buffers read pre-update.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            col_vec[r] = lb[K-2-r][col];
        end
        col_vec[K-1] = pixel_in;
    end

    // Next window: shift every row left by one and insert the new column at k=K-1.
    always_comb begin
        for (int c = 0; c < IN_CHANNEL; c++) begin
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K - 1; k++) begin
                    win_next[c][r][k] = win[c][r][k+1];
                end
                win_next[c][r][K-1] = col_vec[r][c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pack the next window in (channel, row, column) order, column fastest.
    always_comb begin
        win_flat = '0;
        for (int c = 0; c < IN_CHANNEL; c++) begin
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K; k++) begin
                    win_flat[((c*K + r)*K + k)*DATA_WIDTH +: DATA_WIDTH] = win_next[c][r][k];
                end
            end
        end
    end

    // Line-buffer row-shift chain; RAM-like, so no reset (stale rows are never emitted).
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][col] <= pixel_in;
            for (int i = 1; i < K - 1; i++) begin
                lb[i][col] <= lb[i-1][col];
            end
        end
    end

    // Raster position counters, advancing on each accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Working window register, shifted on every accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < IN_CHANNEL; c++) begin
                for (int r = 0; r < K; r++) begin
                    for (int k = 0; k < K; k++) begin
                        win[c][r][k] <= '0;
                    end
                end
            end
        end else if (accept) begin
            win <= win_next;
        end
    end

    // Output stage: window_data only loads on an emitted window and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            window_data  <= '0;
        end else if (accept) begin
            window_valid <= emit;
            frame_done   <= emit && row_last && col_last;
            if (emit) begin
                window_data <= win_flat;
            end
`ifdef CONV_WINDOW_GEN_BACKPRESSURE_EN
        end else if (win_ready) begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end
`else
        end else begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed testbench for conv_window_gen with default parameters.
module tb_conv_window_gen;

    localparam int DW   = 8;
    localparam int K    = 3;
    localparam int CH   = 3;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int PW   = CH * DW;
    localparam int WW   = CH * K * K * DW;
    localparam int NWIN = (W - K + 1) * (H - K + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          pixel_valid;
    logic [PW-1:0] pixel_in;
    logic          pixel_ready;
    logic          win_ready;
    logic          window_valid;
    logic [WW-1:0] window_data;
    logic          frame_done;

    int total = 0;
    int bad   = 0;

    logic [WW-1:0] obs_data[$];
    bit            obs_done[$];
    int            stray_done;
    int            valid_no_accept;
    int            first_win_pix;
    int            drive_timeout;
    bit            all_ones;
    int            stall_left;
    int            stall_cycles;
    int            stall_bad_data;
    int            stall_bad_pr;
    logic [WW-1:0] stall_snap;

    always #5 clk = ~clk;

    conv_window_gen #(
        .DATA_WIDTH (DW),
        .KERNEL_SIZE(K),
        .IN_CHANNEL (CH),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_valid (pixel_valid),
        .pixel_in    (pixel_in),
        .pixel_ready (pixel_ready),
`ifdef CONV_WINDOW_GEN_BACKPRESSURE_EN
        .win_ready   (win_ready),
`endif
        .window_valid(window_valid),
        .window_data (window_data),
        .frame_done  (frame_done)
    );

    function automatic logic [PW-1:0] pix(input int base, input int r, input int c);
        logic [PW-1:0] p;
        for (int ch = 0; ch < CH; ch++)
            p[ch*DW +: DW] = all_ones ? 8'hFF : 8'((base + r*W + c + ch*64) % 256);
        return p;
    endfunction

    // Expected n-th window of a frame: top-left at (n / (W-K+1), n % (W-K+1)).
    function automatic logic [WW-1:0] exp_window(input int base, input int n);
        logic [WW-1:0] w;
        int r0, c0;
        r0 = n / (W - K + 1);
        c0 = n % (W - K + 1);
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < K; r++)
                for (int k = 0; k < K; k++)
                    w[((ch*K + r)*K + k)*DW +: DW] =
                        all_ones ? 8'hFF : 8'((base + (r0 + r)*W + (c0 + k) + ch*64) % 256);
        return w;
    endfunction

    task automatic clear_obs();
        obs_data.delete();
        obs_done.delete();
        stray_done      = 0;
        valid_no_accept = 0;
        first_win_pix   = -1;
        drive_timeout   = 0;
        stall_cycles    = 0;
        stall_bad_data  = 0;
        stall_bad_pr    = 0;
    endtask

    // Drives npix pixels of one frame (optional idle every idle_period cycles) and records windows.
    task automatic drive_frame(input int base, input int idle_period, input int npix);
        int r = 0, c = 0, sent = 0, cyc = 0;
        bit acc;
        while (sent < npix) begin
            if (cyc >= 4*npix + 50) begin
                drive_timeout++;
                break;
            end
            if (idle_period > 0 && (cyc % idle_period) == idle_period - 1) begin
                pixel_valid = 1'b0;
            end else begin
                pixel_valid = 1'b1;
                pixel_in    = pix(base, r, c);
            end
            acc = pixel_valid && pixel_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (window_valid && !acc) valid_no_accept++;
            if (window_valid && first_win_pix < 0) first_win_pix = acc ? r*W + c : -2;
            if (window_valid && stall_left > 0) begin
                if (stall_cycles == 0) stall_snap = window_data;
                win_ready = 1'b0;
                #1;
                if (window_data !== stall_snap) stall_bad_data++;
                if (pixel_ready !== 1'b0) stall_bad_pr++;
                stall_cycles++;
                stall_left--;
            end else begin
                win_ready = 1'b1;
            end
            if (window_valid && win_ready) begin
                obs_data.push_back(window_data);
                obs_done.push_back(frame_done);
            end
            if (frame_done && !window_valid) stray_done++;
            if (acc) begin
                sent++;
                if (c == W - 1) begin
                    c = 0;
                    r = (r == H - 1) ? 0 : r + 1;
                end else begin
                    c++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pixel_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (window_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", window_valid); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", frame_done); end
        total++; if (window_data !== '0) begin bad++; $display("FAIL reset_data: got %h expected 0", window_data); end
        total++; if (pixel_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", pixel_ready); end
        rst = 1'b0;
    endtask

    task automatic test_full_frame();
        int exp0[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        logic [WW-1:0] w;
        clear_obs();
        drive_frame(0, 0, W*H);
        pixel_valid = 1'b0;
        total++; if (drive_timeout != 0) begin bad++; $display("FAIL full_timeout: got %0d expected 0", drive_timeout); end
        total++; if (obs_data.size() != NWIN) begin bad++; $display("FAIL full_count: got %0d expected %0d", obs_data.size(), NWIN); end
        total++; if (first_win_pix != 2*W + 2) begin bad++; $display("FAIL full_first_latency: got pixel %0d expected %0d", first_win_pix, 2*W + 2); end
        if (obs_data.size() > 0) begin
            w = obs_data[0];
            for (int i = 0; i < 9; i++) begin
                total++;
                if (w[i*DW +: DW] !== 8'(exp0[i])) begin
                    bad++; $display("FAIL full_first_ch0[%0d]: got %0d expected %0d", i, w[i*DW +: DW], exp0[i]);
                end
            end
        end
        for (int n = 0; n < obs_data.size() && n < NWIN; n++) begin
            total++;
            if (obs_data[n] !== exp_window(0, n)) begin
                bad++; $display("FAIL full_win[%0d]: got %h expected %h", n, obs_data[n], exp_window(0, n));
            end
            total++;
            if (obs_done[n] !== (n == NWIN - 1)) begin
                bad++; $display("FAIL full_done[%0d]: got %b expected %b", n, obs_done[n], n == NWIN - 1);
            end
        end
        if (obs_data.size() == NWIN) begin
            w = obs_data[NWIN-1];
            total++; if (w[DW-1:0] !== 8'd45) begin bad++; $display("FAIL full_last_topleft: got %0d expected 45", w[DW-1:0]); end
        end
        total++; if (stray_done != 0) begin bad++; $display("FAIL full_stray_done: got %0d expected 0", stray_done); end
    endtask

    task automatic test_bubbles();
        clear_obs();
        drive_frame(0, 3, W*H);
        pixel_valid = 1'b0;
        total++; if (drive_timeout != 0) begin bad++; $display("FAIL bubble_timeout: got %0d expected 0", drive_timeout); end
        total++; if (obs_data.size() != NWIN) begin bad++; $display("FAIL bubble_count: got %0d expected %0d", obs_data.size(), NWIN); end
        total++; if (valid_no_accept != 0) begin bad++; $display("FAIL bubble_valid_after_idle: got %0d expected 0", valid_no_accept); end
        for (int n = 0; n < obs_data.size() && n < NWIN; n++) begin
            total++;
            if (obs_data[n] !== exp_window(0, n)) begin
                bad++; $display("FAIL bubble_win[%0d]: got %h expected %h", n, obs_data[n], exp_window(0, n));
            end
            total++;
            if (obs_done[n] !== (n == NWIN - 1)) begin
                bad++; $display("FAIL bubble_done[%0d]: got %b expected %b", n, obs_done[n], n == NWIN - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        logic [WW-1:0] w;
        clear_obs();
        drive_frame(0, 0, W*H);
        drive_frame(100, 0, W*H);
        pixel_valid = 1'b0;
        total++; if (obs_data.size() != 2*NWIN) begin bad++; $display("FAIL b2b_count: got %0d expected %0d", obs_data.size(), 2*NWIN); end
        for (int n = 0; n < obs_data.size() && n < 2*NWIN; n++) begin
            if (obs_done[n]) ndone++;
            total++;
            if (obs_data[n] !== exp_window(n < NWIN ? 0 : 100, n % NWIN)) begin
                bad++; $display("FAIL b2b_win[%0d]: got %h expected %h", n, obs_data[n], exp_window(n < NWIN ? 0 : 100, n % NWIN));
            end
        end
        total++; if (ndone != 2) begin bad++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
        if (obs_data.size() > NWIN) begin
            w = obs_data[NWIN];
            total++; if (w[DW-1:0] !== 8'd100) begin bad++; $display("FAIL b2b_f2_topleft: got %0d expected 100", w[DW-1:0]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        drive_frame(0, 0, 20);
        rst = 1'b1;
        pixel_valid = 1'b1;
        pixel_in = pix(0, 7, 7);
        @(posedge clk);
        #1;
        total++; if (window_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b expected 0", window_valid); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b expected 0", frame_done); end
        total++; if (window_data !== '0) begin bad++; $display("FAIL rstmid_data: got %h expected 0", window_data); end
        rst = 1'b0;
        clear_obs();
        drive_frame(0, 0, W*H);
        pixel_valid = 1'b0;
        total++; if (obs_data.size() != NWIN) begin bad++; $display("FAIL rstmid_count: got %0d expected %0d", obs_data.size(), NWIN); end
        total++; if (first_win_pix != 2*W + 2) begin bad++; $display("FAIL rstmid_first_latency: got pixel %0d expected %0d", first_win_pix, 2*W + 2); end
        for (int n = 0; n < obs_data.size() && n < NWIN; n++) begin
            total++;
            if (obs_data[n] !== exp_window(0, n)) begin
                bad++; $display("FAIL rstmid_win[%0d]: got %h expected %h", n, obs_data[n], exp_window(0, n));
            end
            total++;
            if (obs_done[n] !== (n == NWIN - 1)) begin
                bad++; $display("FAIL rstmid_done[%0d]: got %b expected %b", n, obs_done[n], n == NWIN - 1);
            end
        end
    endtask

    task automatic test_all_ones();
        clear_obs();
        all_ones = 1'b1;
        drive_frame(0, 0, W*H);
        pixel_valid = 1'b0;
        all_ones = 1'b0;
        total++; if (obs_data.size() != NWIN) begin bad++; $display("FAIL ones_count: got %0d expected %0d", obs_data.size(), NWIN); end
        for (int n = 0; n < obs_data.size(); n++) begin
            total++;
            if (obs_data[n] !== {WW{1'b1}}) begin
                bad++; $display("FAIL ones_win[%0d]: got %h expected all ones", n, obs_data[n]);
            end
        end
    endtask

`ifdef CONV_WINDOW_GEN_BACKPRESSURE_EN
    task automatic test_backpressure();
        clear_obs();
        stall_left = 5;
        drive_frame(0, 0, W*H);
        stall_left = 0;
        pixel_valid = 1'b0;
        win_ready = 1'b1;
        total++; if (stall_cycles != 5) begin bad++; $display("FAIL bp_stall_cycles: got %0d expected 5", stall_cycles); end
        total++; if (stall_bad_data != 0) begin bad++; $display("FAIL bp_data_unstable: got %0d expected 0", stall_bad_data); end
        total++; if (stall_bad_pr != 0) begin bad++; $display("FAIL bp_pixel_ready: got %0d expected 0", stall_bad_pr); end
        total++; if (obs_data.size() != NWIN) begin bad++; $display("FAIL bp_count: got %0d expected %0d", obs_data.size(), NWIN); end
        for (int n = 0; n < obs_data.size() && n < NWIN; n++) begin
            total++;
            if (obs_data[n] !== exp_window(0, n)) begin
                bad++; $display("FAIL bp_win[%0d]: got %h expected %h", n, obs_data[n], exp_window(0, n));
            end
            total++;
            if (obs_done[n] !== (n == NWIN - 1)) begin
                bad++; $display("FAIL bp_done[%0d]: got %b expected %b", n, obs_done[n], n == NWIN - 1);
            end
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        pixel_valid = 1'b0;
        pixel_in    = '0;
        win_ready   = 1'b1;
        all_ones    = 1'b0;
        stall_left  = 0;
        clear_obs();
        test_reset();
        test_full_frame();
        test_bubbles();
        test_back_to_back();
        test_reset_mid();
        test_all_ones();
`ifdef CONV_WINDOW_GEN_BACKPRESSURE_EN
        test_backpressure();
`endif
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
